hex_to_pixel_q16: RTL
=====================

# hex_to_pixel_q16

Streaming inverse of the hex rasterizer. The block accepts a sparse batch of integer axial hex coordinates (q, r) with per-lane depth and a lane-valid mask. It emits one pixel-space Q16.16 hex-centre (x, y) per cycle for each masked-in lane, in ascending lane order. It sits between the hex-tile stage and the pixel shading/blend stage, and uses valid/ready handshakes on both sides.

## Interface
- BATCH, 10, lanes per input batch
- HEX_SIZE_Q16, 32'h0001_0000, hex outer radius in Q16.16 (pointy-top layout)
- clk  input  1  clock; all logic on posedge
- reset  input  1  synchronous, active-high
- valid_in  input  1  batch present
- ready_in  output  1  block can accept a batch
- lane_mask  input  BATCH  bit i = lane i is live (sparse batch)
- q  input  16 signed ×BATCH  axial q per lane
- r  input  16 signed ×BATCH  axial r per lane
- depth_in  input  8 ×BATCH  per-lane depth, passed through
- valid_out  output  1  output beat valid
- ready_out  input  1  downstream accepts beat
- x_f  output  32 signed  pixel x, Q16.16
- y_f  output  32 signed  pixel y, Q16.16
- depth_out  output  8  depth of emitted lane
- lane_out  output  $clog2(BATCH)  source lane index
- last_out  output  1  final live lane of the batch

## Operation
- Constants, computed at elaboration with a 64-bit intermediate:
  - KX = (SQRT3_Q16 · HEX_SIZE_Q16) >>> 16
  - KY = (3 · HEX_SIZE_Q16) >>> 1
  - SQRT3_Q16 = 113512
- Per lane:
  - t = 2q + r, 18-bit signed
  - x = (t · KX) >>> 1, arithmetic shift
  - y = r · KY
  - Products are 50-bit signed. Each result saturates to [0x8000_0000, 0x7FFF_FFFF].
- FSM has two states, IDLE and DRAIN.
  - ready_in = (state == IDLE).
  - IDLE, on valid_in && ready_in with lane_mask ≠ 0: register q, r, depth_in and lane_mask into the batch buffer; go to DRAIN.
  - IDLE, on valid_in && ready_in with lane_mask == 0: the batch is consumed and dropped. No output. Stay in IDLE.
  - DRAIN, each advancing cycle: pick the lowest set bit of the remaining mask, clear it, and issue that lane into the pipeline.
  - The lane that leaves the remaining mask empty is tagged last. After issuing it, go to IDLE.
- Pipeline: S1 is lane select plus multiply, registered. S2 is shift, saturate and output registers.
- Advance condition: adv = !valid_out || ready_out. When adv is low, the whole pipeline holds and mask clearing stops. Outputs stay stable while valid_out && !ready_out.
- A new batch can be accepted while the previous batch's last beat is still in S1/S2. Ordering across batches is preserved.

## Timing
- Reset values: ready_in=1, valid_out=0, x_f=0, y_f=0, depth_out=0, lane_out=0, last_out=0. State = IDLE, mask = 0, S1 valid = 0.
- Latency with no backpressure: batch accepted at edge T; first beat is valid after edge T+2. Then one beat per cycle. A batch with N live lanes occupies DRAIN for N cycles.
- Back-to-back batches: ready_in returns high the cycle after the last lane issues. Minimum cadence is N+1 cycles per batch.
- Reset asserted mid-DRAIN or mid-stall: everything returns to reset values on the next edge. In-flight beats are discarded and no last_out is emitted.
- valid_in while in DRAIN: ignored, because ready_in = 0.
- ready_out low on the last beat: last_out is held with the beat. ready_in may already be high and a new batch may be accepted; its lanes stall in S1.

## Structure
- Package hex_raster_pkg holds:
  - the SQRT3_Q16 constant
  - the q16_t typedef (logic signed [31:0])
  - the enum {IDLE, DRAIN}
  - a sat32 function (50-bit to 32-bit saturation)
- The sub-module hex_lane_picker is a parameterised find-first-set over BATCH bits. It returns the index, a found flag, and an is_last flag (the remaining mask with that bit cleared is zero).

## Test plan
- HEX_SIZE 1.0, single lane (q=1, r=0), mask=0x001 → x_f=113512, y_f=0, lane_out=0, last_out=1, first beat 2 cycles after accept.
- Lanes 3, 7 live (q=0,r=1; q=-1,r=-1), mask=0x088 → beats in order: (56756, 98304, lane 3, last=0), then (-170268, -98304, lane 7, last=1).
- q=32767, r=32767 and q=-32768, r=-32768 → x_f/y_f saturate to 0x7FFF_FFFF and 0x8000_0000 respectively.
- Full mask 0x3FF with ready_out toggling every other cycle → 10 beats, lane 0..9, no loss or duplication, outputs stable during stall, depth passthrough matches.
- mask=0x000 with valid_in high → no valid_out ever, ready_in stays 1. A following mask=0x001 batch emits normally.
- Reset pulsed while lane 4 of a 10-lane batch is stalled → valid_out=0 and ready_in=1 on the next cycle, no further beats, next batch processed from lane 0.

Source files
------------

// File: rtl/hex_to_pixel_q16_pkg.sv
// Shared constants, types and saturation helper for the hex-to-pixel stage.
package hex_raster_pkg;

  localparam logic signed [63:0] SQRT3_Q16 = 64'sd113512;

  typedef logic signed [31:0] q16_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  function automatic q16_t sat32(input logic signed [49:0] v);
    if (v > 50'sd2147483647) begin
      return 32'sh7FFF_FFFF;
    end else if (v < -50'sd2147483648) begin
      return 32'sh8000_0000;
    end else begin
      return q16_t'(v[31:0]);
    end
  endfunction

endpackage

// File: rtl/hex_to_pixel_q16_if.sv
// Batch-in and pixel-beat-out handshake bundles for the hex-to-pixel stage.
interface hex_batch_if #(
  parameter int BATCH = 10
);
  logic                  valid_in;
  logic                  ready_in;
  logic [BATCH-1:0]      lane_mask;
  logic [BATCH-1:0][15:0] q;
  logic [BATCH-1:0][15:0] r;
  logic [BATCH-1:0][7:0] depth_in;

  modport master (output valid_in, lane_mask, q, r, depth_in, input ready_in);
  modport slave  (input valid_in, lane_mask, q, r, depth_in, output ready_in);
endinterface

interface hex_pix_if #(
  parameter int BATCH = 10,
  parameter int LW    = ($clog2(BATCH) > 0) ? $clog2(BATCH) : 1
);
  logic               valid_out;
  logic               ready_out;
  logic signed [31:0] x_f;
  logic signed [31:0] y_f;
  logic [7:0]         depth_out;
  logic [LW-1:0]      lane_out;
  logic               last_out;

  modport master (output valid_out, x_f, y_f, depth_out, lane_out, last_out, input ready_out);
  modport slave  (input valid_out, x_f, y_f, depth_out, lane_out, last_out, output ready_out);
endinterface

// File: rtl/hex_to_pixel_q16_picker.sv
// Find-first-set over a lane mask; is_last flags that the chosen bit is the only one left.
module hex_lane_picker #(
  parameter int N = 10,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] mask_i,
  output logic [W-1:0] idx_o,
  output logic         found_o,
  output logic         last_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o   = W'(i);
        found_o = 1'b1;
      end
    end
    last_o = found_o && ((mask_i & (mask_i - N'(1))) == '0);
  end

endmodule

// File: rtl/hex_to_pixel_q16.sv
// Axial hex (q,r) batch -> per-lane Q16.16 pixel centres, lowest lane first; 2-cycle latency.
// Whole pipeline freezes while an output beat is stalled; a new batch may load during that stall.
module hex_to_pixel_q16
  import hex_raster_pkg::*;
#(
  parameter int          BATCH        = 10,
  parameter logic [31:0] HEX_SIZE_Q16 = 32'h0001_0000
) (
  input  logic       clk,
  input  logic       reset,
  hex_batch_if.slave in_if,
  hex_pix_if.master  out_if
);

  localparam int LW = (BATCH > 1) ? $clog2(BATCH) : 1;

  localparam logic signed [63:0] HEX64 = $signed({32'd0, HEX_SIZE_Q16});
  localparam logic signed [63:0] KX64  = (SQRT3_Q16 * HEX64) >>> 16;
  localparam logic signed [63:0] KY64  = (64'sd3 * HEX64) >>> 1;
  localparam logic signed [49:0] KX    = 50'(KX64);
  localparam logic signed [49:0] KY    = 50'(KY64);

  state_e                  state_q, state_d;
  logic [BATCH-1:0]        mask_q;
  logic [BATCH-1:0][15:0]  q_buf_q;
  logic [BATCH-1:0][15:0]  r_buf_q;
  logic [BATCH-1:0][7:0]   d_buf_q;

  logic [LW-1:0] pick_idx;
  logic          pick_found;
  logic          pick_last;

  logic adv;
  logic load;
  logic issue;

  logic               s1_vld_q;
  logic signed [49:0] s1_px_q;
  logic signed [49:0] s1_py_q;
  logic [7:0]         s1_depth_q;
  logic [LW-1:0]      s1_lane_q;
  logic               s1_last_q;

  logic          vout_q;
  q16_t          x_q;
  q16_t          y_q;
  logic [7:0]    depth_q;
  logic [LW-1:0] lane_q;
  logic          last_q;

  hex_lane_picker #(.N(BATCH), .W(LW)) u_picker (
    .mask_i  (mask_q),
    .idx_o   (pick_idx),
    .found_o (pick_found),
    .last_o  (pick_last)
  );

  assign adv   = !vout_q || out_if.ready_out;
  assign load  = in_if.valid_in && (state_q == IDLE) && (in_if.lane_mask != '0);
  assign issue = (state_q == DRAIN) && adv && pick_found;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = DRAIN;
      DRAIN:   if (issue && pick_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_if.ready_in = (state_q == IDLE);
  end

  // An all-zero mask is consumed in IDLE without touching the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q  <= '0;
      q_buf_q <= '0;
      r_buf_q <= '0;
      d_buf_q <= '0;
    end else if (load) begin
      mask_q  <= in_if.lane_mask;
      q_buf_q <= in_if.q;
      r_buf_q <= in_if.r;
      d_buf_q <= in_if.depth_in;
    end else if (issue) begin
      mask_q <= mask_q & (mask_q - BATCH'(1));
    end
  end

  logic [15:0]        sel_q;
  logic [15:0]        sel_r;
  logic signed [17:0] t;
  logic signed [49:0] t_w;
  logic signed [49:0] r_w;
  logic signed [49:0] px_d;
  logic signed [49:0] py_d;

  assign sel_q = q_buf_q[pick_idx];
  assign sel_r = r_buf_q[pick_idx];
  assign t     = $signed({sel_q[15], sel_q, 1'b0}) + $signed({{2{sel_r[15]}}, sel_r});
  assign t_w   = 50'(t);
  assign r_w   = 50'($signed(sel_r));
  assign px_d  = t_w * KX;
  assign py_d  = r_w * KY;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q   <= 1'b0;
      s1_px_q    <= '0;
      s1_py_q    <= '0;
      s1_depth_q <= '0;
      s1_lane_q  <= '0;
      s1_last_q  <= 1'b0;
    end else if (adv) begin
      s1_vld_q <= issue;
      if (issue) begin
        s1_px_q    <= px_d;
        s1_py_q    <= py_d;
        s1_depth_q <= d_buf_q[pick_idx];
        s1_lane_q  <= pick_idx;
        s1_last_q  <= pick_last;
      end
    end
  end

  logic signed [49:0] px_sh;
  assign px_sh = s1_px_q >>> 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      vout_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      depth_q <= '0;
      lane_q  <= '0;
      last_q  <= 1'b0;
    end else if (adv) begin
      vout_q <= s1_vld_q;
      if (s1_vld_q) begin
        x_q     <= sat32(px_sh);
        y_q     <= sat32(s1_py_q);
        depth_q <= s1_depth_q;
        lane_q  <= s1_lane_q;
        last_q  <= s1_last_q;
      end
    end
  end

  assign out_if.valid_out = vout_q;
  assign out_if.x_f       = x_q;
  assign out_if.y_f       = y_q;
  assign out_if.depth_out = depth_q;
  assign out_if.lane_out  = lane_q;
  assign out_if.last_out  = last_q;

endmodule
